// File: rtl/npu_result_collector_if.sv
// Byte-read port between the NPU core output FIFO and the result collector.
// RD_EN pops one byte; FIFO_DATA carries that byte on the following cycle.
interface npu_result_collector_if;
    logic [7:0] FIFO_DATA;
    logic       FIFO_EMPTY;
    logic       RD_EN;

    // Handshake: a byte moves when RD_EN is high at a rising clock edge.
    // RD_EN is only raised while FIFO_EMPTY is low, so EMPTY acts as !valid
    // and RD_EN as ready. The popped byte is presented on FIFO_DATA for the
    // whole next cycle and is sampled at the end of that cycle.
    modport master (
        output RD_EN,
        input  FIFO_DATA,
        input  FIFO_EMPTY
    );

    modport slave (
        input  RD_EN,
        output FIFO_DATA,
        output FIFO_EMPTY
    );
endinterface

// File: rtl/npu_result_collector.sv
// Drains 2*NUM_CLASSES bytes from the NPU output FIFO, rebuilds little-endian
// signed 16-bit scores and keeps a streaming argmax of them.
module npu_result_collector #(
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 8
) (
    input  logic                    CLKEXT,
    input  logic                    RST,
    input  logic                    START,
    npu_result_collector_if.master  fifo,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [15:0]             WORD_OUT,
    output logic                    WORD_VALID,
    output logic [IDX_W-1:0]        WORD_IDX,
    output logic [IDX_W-1:0]        CLASS_IDX,
    output logic [15:0]             CLASS_SCORE,
    output logic [1:0]              STATE_DBG
);

    localparam int                TOTAL_BYTES = 2 * NUM_CLASSES;
    localparam int                CNT_W       = $clog2(TOTAL_BYTES + 1);
    localparam logic [CNT_W-1:0]  TOTAL_C     = CNT_W'(TOTAL_BYTES);
    localparam logic [IDX_W-1:0]  LAST_WORD   = IDX_W'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  req_cnt;
    logic [IDX_W-1:0]  word_cnt;
    logic              phase;
    logic              rd_pend;
    logic [7:0]        low_byte;
    logic [15:0]       word;

    assign word = {fifo.FIFO_DATA, low_byte};

    // The request counter caps reads so surplus FIFO bytes stay for the next run.
    assign fifo.RD_EN = (state == S_READ) && !fifo.FIFO_EMPTY && (req_cnt < TOTAL_C);

    assign BUSY      = (state == S_READ);
    assign STATE_DBG = state;

    always_ff @(posedge CLKEXT or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            req_cnt     <= '0;
            word_cnt    <= '0;
            phase       <= 1'b0;
            rd_pend     <= 1'b0;
            low_byte    <= '0;
            DONE        <= 1'b0;
            WORD_OUT    <= '0;
            WORD_VALID  <= 1'b0;
            WORD_IDX    <= '0;
            CLASS_IDX   <= '0;
            CLASS_SCORE <= '0;
        end else begin
            WORD_VALID <= 1'b0;
            DONE       <= 1'b0;
            rd_pend    <= fifo.RD_EN;
            if (fifo.RD_EN) begin
                req_cnt <= req_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (START) begin
                        state    <= S_READ;
                        req_cnt  <= '0;
                        word_cnt <= '0;
                        phase    <= 1'b0;
                        rd_pend  <= 1'b0;
                    end
                end

                S_READ: begin
                    if (rd_pend) begin
                        if (!phase) begin
                            low_byte <= fifo.FIFO_DATA;
                            phase    <= 1'b1;
                        end else begin
                            phase      <= 1'b0;
                            WORD_OUT   <= word;
                            WORD_VALID <= 1'b1;
                            WORD_IDX   <= word_cnt;
                            // Strict compare: on a tie the earlier class wins.
                            if ((word_cnt == '0) || ($signed(word) > $signed(CLASS_SCORE))) begin
                                CLASS_SCORE <= word;
                                CLASS_IDX   <= word_cnt;
                            end
                            word_cnt <= word_cnt + 1'b1;
                            if (word_cnt == LAST_WORD) begin
                                state <= S_FINISH;
                                DONE  <= 1'b1;
                            end
                        end
                    end
                end

                S_FINISH: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npu_result_collector.sv
// Directed bench for npu_result_collector: byte-FIFO model, word monitor and
// immediate-assertion checks against hand-computed scores.
module tb_npu_result_collector;

    localparam int IDX_W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;

    always #5 clk = ~clk;

    npu_result_collector_if bus ();

    logic              busy, done, word_valid;
    logic [15:0]       word_out, class_score;
    logic [IDX_W-1:0]  word_idx, class_idx;
    logic [1:0]        state_dbg;

    npu_result_collector #(.NUM_CLASSES(10), .IDX_W(IDX_W)) dut (
        .CLKEXT      (clk),
        .RST         (rst),
        .START       (start),
        .fifo        (bus.master),
        .BUSY        (busy),
        .DONE        (done),
        .WORD_OUT    (word_out),
        .WORD_VALID  (word_valid),
        .WORD_IDX    (word_idx),
        .CLASS_IDX   (class_idx),
        .CLASS_SCORE (class_score),
        .STATE_DBG   (state_dbg)
    );

    // ---------------- FIFO model ----------------
    logic [7:0] mem [0:255];
    int wr_ptr  = 0;
    int rd_ptr  = 0;
    int skip_to = 0;
    int rd_n    = 0;
    int bad_n   = 0;

    assign bus.FIFO_EMPTY = (rd_ptr >= wr_ptr);

    always @(posedge clk) begin
        if (bus.RD_EN && (rd_ptr >= wr_ptr)) bad_n <= bad_n + 1;
        if (rd_ptr < skip_to) begin
            rd_ptr <= skip_to;
        end else if (bus.RD_EN) begin
            bus.FIFO_DATA <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + 1;
            rd_n          <= rd_n + 1;
        end
    end

    // ---------------- output monitor ----------------
    logic [15:0]      got_word [0:255];
    logic [IDX_W-1:0] got_idx  [0:255];
    int got_n  = 0;
    int done_n = 0;

    always @(posedge clk) begin
        #1;
        if (word_valid) begin
            got_word[got_n] = word_out;
            got_idx[got_n]  = word_idx;
            got_n = got_n + 1;
        end
        if (done) done_n = done_n + 1;
    end

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic push_word(input logic [15:0] w);
        push_byte(w[7:0]);
        push_byte(w[15:8]);
    endtask

    task automatic begin_run(output int bw, output int bd, output int br);
        @(negedge clk);
        bw = got_n;
        bd = done_n;
        br = rd_n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic end_run(input string tag, input int bw, input int bd, input int br,
                           input logic [IDX_W-1:0] e_idx, input logic [15:0] e_score);
        int k;
        k = 0;
        while (done_n == bd && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done_seen"}, 32'(done_n > bd), 32'd1);
        check({tag, "_done_level"}, 32'(done), 32'd1);
        check({tag, "_busy_in_finish"}, 32'(busy), 32'd0);
        check({tag, "_class_idx"}, 32'(class_idx), 32'(e_idx));
        check({tag, "_class_score"}, 32'(class_score), 32'(e_score));
        check({tag, "_rd_count"}, 32'(rd_n - br), 32'd20);
        check({tag, "_word_count"}, 32'(got_n - bw), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check({tag, "_word"}, 32'(got_word[bw + i]), 32'(exp_q[i]));
            check({tag, "_word_idx"}, 32'(got_idx[bw + i]), 32'(i));
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_done_once"}, 32'(done_n - bd), 32'd1);
        check({tag, "_idle"}, 32'(state_dbg), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    int bw, bd, br, k;

    initial begin
        // Reset state
        #2;
        check("rst_word_out", 32'(word_out), 32'd0);
        check("rst_class_idx", 32'(class_idx), 32'd0);
        check("rst_class_score", 32'(class_score), 32'd0);
        check("rst_rd_en", 32'(bus.RD_EN), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: basic run, tie at index 5 keeps index 3
        exp_q = '{16'd5, 16'd9, 16'd3, 16'd200, 16'd7, 16'd200, 16'd1, 16'd0, 16'd2, 16'd4};
        foreach (exp_q[i]) push_word(exp_q[i]);
        begin_run(bw, bd, br);
        check("t1_busy", 32'(busy), 32'd1);
        end_run("t1", bw, bd, br, 8'd3, 16'h00C8);

        // 2: all negative, -300 at index 6 is the maximum
        exp_q = '{16'hFC18, 16'hF830, 16'hFC18, 16'hFA24, 16'hFC18,
                  16'hFC18, 16'hFED4, 16'hFC18, 16'h8000, 16'hFC18};
        foreach (exp_q[i]) push_word(exp_q[i]);
        begin_run(bw, bd, br);
        end_run("t2", bw, bd, br, 8'd6, 16'hFED4);

        // 3: EMPTY stall after 3 bytes; word 1 spans the stall
        exp_q = '{16'd10, 16'h01F4, 16'd30, 16'd40, 16'hFFFB,
                  16'd60, 16'd499, 16'd80, 16'd90, 16'd100};
        push_byte(8'h0A);
        push_byte(8'h00);
        push_byte(8'hF4);
        begin_run(bw, bd, br);
        repeat (15) @(negedge clk);
        check("t3_stall_rd_count", 32'(rd_n - br), 32'd3);
        check("t3_stall_rd_en", 32'(bus.RD_EN), 32'd0);
        check("t3_stall_busy", 32'(busy), 32'd1);
        check("t3_stall_words", 32'(got_n - bw), 32'd1);
        push_byte(8'h01);
        for (int i = 2; i < 10; i++) push_word(exp_q[i]);
        end_run("t3", bw, bd, br, 8'd1, 16'h01F4);

        // 4: 24 bytes queued, only 20 consumed; leftovers start the next run
        exp_q = '{16'd100, 16'hFFFF, 16'd50, 16'd100, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12};
        foreach (exp_q[i]) push_word(exp_q[i]);
        push_word(16'd3);
        push_word(16'd1000);
        begin_run(bw, bd, br);
        end_run("t4a", bw, bd, br, 8'd0, 16'd100);
        check("t4_fifo_not_empty", 32'(bus.FIFO_EMPTY), 32'd0);
        check("t4_fifo_left", 32'(wr_ptr - rd_ptr), 32'd4);
        exp_q = '{16'd3, 16'd1000, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd1001};
        for (int i = 2; i < 10; i++) push_word(exp_q[i]);
        begin_run(bw, bd, br);
        end_run("t4b", bw, bd, br, 8'd9, 16'd1001);

        // 5: reset after 7 bytes, then a clean run starting on a low byte
        exp_q = '{16'd5, 16'd9, 16'd3, 16'd200, 16'd7, 16'd200, 16'd1, 16'd0, 16'd2, 16'd4};
        foreach (exp_q[i]) push_word(exp_q[i]);
        begin_run(bw, bd, br);
        k = 0;
        while ((rd_n - br) < 7 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("t5_reached_7", 32'(rd_n - br), 32'd7);
        rst = 1'b1;
        #1;
        check("t5_rst_word_out", 32'(word_out), 32'd0);
        check("t5_rst_word_idx", 32'(word_idx), 32'd0);
        check("t5_rst_class_idx", 32'(class_idx), 32'd0);
        check("t5_rst_class_score", 32'(class_score), 32'd0);
        check("t5_rst_rd_en", 32'(bus.RD_EN), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_no_reads_after_rst", 32'(rd_n - br), 32'd7);
        check("t5_idle_after_rst", 32'(busy), 32'd0);
        skip_to = wr_ptr;
        repeat (2) @(negedge clk);
        exp_q = '{16'h0102, 16'h0201, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        foreach (exp_q[i]) push_word(exp_q[i]);
        begin_run(bw, bd, br);
        end_run("t5", bw, bd, br, 8'd1, 16'h0201);

        // 6: START mid-run and in the FINISH cycle are ignored
        exp_q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10};
        foreach (exp_q[i]) push_word(exp_q[i]);
        begin_run(bw, bd, br);
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (done_n == bd && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("t6_finish_state", 32'(state_dbg), 32'd2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t6_start_in_finish_ignored", 32'(state_dbg), 32'd0);
        @(negedge clk);
        check("t6_still_idle", 32'(busy), 32'd0);
        check("t6_class_idx", 32'(class_idx), 32'd9);
        check("t6_class_score", 32'(class_score), 32'd10);
        check("t6_rd_count", 32'(rd_n - br), 32'd20);
        check("t6_word_count", 32'(got_n - bw), 32'd10);
        check("t6_last_word", 32'(got_word[bw + 9]), 32'(exp_q[9]));
        check("t6_single_done", 32'(done_n - bd), 32'd1);

        check("no_read_while_empty", 32'(bad_n), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
